// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, word/block types and key-schedule helpers.
package aes_pkg;
    localparam logic [3:0] NUM_ROUNDS = 4'd10;
    typedef logic [31:0] word_t;
    typedef logic [127:0] block_t;
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [NUM_ROUNDS:1][7:0] RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };
    function automatic word_t rot_word(word_t w);
        return {w[23:0], w[31:24]};
    endfunction
endpackage

// File: rtl/aes_inv_keyexpansion_if.sv
// aes_inv_keyexpansion_if: round-key stream between the inverse key schedule and its consumer.
interface aes_inv_keyexpansion_if;
    import aes_pkg::*;
    logic start;
    block_t last_key;
    logic ready;
    block_t round_key;
    logic [3:0] round_idx;
    logic valid;
    logic busy;
    logic finish;
    modport master (
        output start, last_key, ready,
        input round_key, round_idx, valid, busy, finish
    );
    modport slave (
        input start, last_key, ready,
        output round_key, round_idx, valid, busy, finish
    );
endinterface

// File: rtl/sbox.sv
// sbox: forward AES S-box, GF(2^8) inverse (x^254) followed by the affine transform.
module sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ a : p;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction
    function automatic logic [7:0] ginv(logic [7:0] x);
        logic [7:0] s;
        logic [7:0] r;
        s = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction
    logic [7:0] b;
    always_comb begin
        b = ginv(a_i);
        y_o = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
endmodule

// File: rtl/aes_inv_keyexpansion.sv
// aes_inv_keyexpansion: walks the AES-128 key schedule backwards from round 10,
// emitting one round key per accepted handshake.
module aes_inv_keyexpansion
    import aes_pkg::*;
(
    input logic clk,
    input logic rst,
    aes_inv_keyexpansion_if.slave bus
);
    state_t state_q, state_d;
    block_t key_q, key_d;
    logic [3:0] idx_q, idx_d;
    logic finish_q, finish_d;
    word_t p0, p1, p2, p3, rot, sub;
    assign p3 = key_q[31:0] ^ key_q[63:32];
    assign p2 = key_q[63:32] ^ key_q[95:64];
    assign p1 = key_q[95:64] ^ key_q[127:96];
    assign rot = rot_word(p3);
    for (genvar b = 0; b < 4; b++) begin : g_sb
        sbox u_sbox (.a_i(rot[8*b +: 8]), .y_o(sub[8*b +: 8]));
    end
    // Rcon index is only meaningful for idx_q in 1..10; p0 is unused at idx 0.
    assign p0 = key_q[127:96] ^ sub ^ {RCON[idx_q], 24'h0};
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            key_q <= '0;
            idx_q <= '0;
            finish_q <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q <= key_d;
            idx_q <= idx_d;
            finish_q <= finish_d;
        end
    end
    always_comb begin
        state_d = state_q;
        key_d = key_q;
        idx_d = idx_q;
        finish_d = 1'b0;
        if (state_q == IDLE) begin
            if (bus.start) begin
                key_d = bus.last_key;
                idx_d = NUM_ROUNDS;
                state_d = RUN;
            end
        end else if (bus.ready) begin
            if (idx_q != 4'd0) begin
                key_d = {p0, p1, p2, p3};
                idx_d = idx_q - 4'd1;
            end else begin
                state_d = IDLE;
                finish_d = 1'b1;
            end
        end
    end
    assign bus.round_key = key_q;
    assign bus.round_idx = idx_q;
    assign bus.valid = (state_q == RUN);
    assign bus.busy = (state_q == RUN);
    assign bus.finish = finish_q;
endmodule

// File: tb/tb_aes_inv_keyexpansion.sv
// tb_aes_inv_keyexpansion: randomized self-checking bench against a forward key-schedule model.
module tb_aes_inv_keyexpansion;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int total = 0;
    int passed = 0;
    logic [7:0] sb [256];
    logic [127:0] exp_rk [0:10];
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    aes_inv_keyexpansion_if ifc();
    aes_inv_keyexpansion dut (.clk(clk), .rst(rst), .bus(ifc));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got %h expected %h", tag, got, exp);
        else passed++;
    endtask

    function automatic logic [7:0] rl(logic [7:0] v, int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    // Classic generator walk: p steps by multiply-by-3, q by divide-by-3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    task automatic expand(input logic [127:0] k0);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 plain, 1 start at idx 5, 2 reset at idx 3, 3 start with final handshake
    task automatic run(input logic [127:0] k0, input int pct, input int mode, input bit fips);
        int n = 0;
        int cyc = 0;
        int e;
        logic held_v = 1'b0;
        logic [127:0] held = '0;
        expand(k0);
        ifc.start = 1'b1;
        ifc.last_key = exp_rk[10];
        step();
        ifc.start = 1'b0;
        ifc.last_key = {$urandom, $urandom, $urandom, $urandom};
        while (n < 11 && cyc < 400) begin
            e = 10 - n;
            if (held_v) check("hold", ifc.round_key, held);
            check("valid", {127'b0, ifc.valid}, 128'd1);
            check("busy", {127'b0, ifc.busy}, 128'd1);
            check("idx", {124'b0, ifc.round_idx}, e);
            check("key", ifc.round_key, exp_rk[e]);
            if (fips && e == 10) check("fips10", ifc.round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
            if (fips && e == 9) check("fips9", ifc.round_key, 128'hac7766f319fadc2128d12941575c006e);
            if (fips && e == 1) check("fips1", ifc.round_key, 128'ha0fafe1788542cb123a339392a6c7605);
            if (fips && e == 0) check("fips0", ifc.round_key, FIPS_KEY);
            if (mode == 2 && e == 3) begin
                rst = 1'b0;
                step();
                rst = 1'b1;
                check("rst_key", ifc.round_key, 128'd0);
                check("rst_idx", {124'b0, ifc.round_idx}, 128'd0);
                check("rst_vld", {126'b0, ifc.valid, ifc.busy}, 128'd0);
                check("rst_fin", {127'b0, ifc.finish}, 128'd0);
                step();
                check("rst_fin2", {126'b0, ifc.finish, ifc.valid}, 128'd0);
                return;
            end
            ifc.ready = ($urandom_range(99) < pct);
            ifc.start = (mode == 1 && e == 5) || (mode == 3 && e == 0 && ifc.ready);
            if (mode == 1 && e == 5) ifc.last_key = '0;
            held_v = !ifc.ready;
            held = ifc.round_key;
            step();
            cyc++;
            if (ifc.ready) n++;
            ifc.start = 1'b0;
        end
        ifc.ready = 1'b0;
        check("accepted", n, 11);
        if (pct >= 100) check("rate", cyc, 11);
        check("finish", {127'b0, ifc.finish}, 128'd1);
        check("done_vld", {126'b0, ifc.valid, ifc.busy}, 128'd0);
        check("done_key", ifc.round_key, exp_rk[0]);
        step();
        check("fin_pulse", {127'b0, ifc.finish}, 128'd0);
        check("idle_vld", {126'b0, ifc.valid, ifc.busy}, 128'd0);
    endtask

    initial begin
        ifc.start = 1'b0;
        ifc.ready = 1'b0;
        ifc.last_key = '0;
        build_sbox();
        repeat (3) step();
        check("rst_key", ifc.round_key, 128'd0);
        check("rst_idx", {124'b0, ifc.round_idx}, 128'd0);
        check("rst_out", {125'b0, ifc.valid, ifc.busy, ifc.finish}, 128'd0);
        rst = 1'b1;
        step();
        run(FIPS_KEY, 100, 0, 1'b1);
        run(FIPS_KEY, 50, 0, 1'b1);
        run(FIPS_KEY, 60, 1, 1'b1);
        run(FIPS_KEY, 100, 2, 1'b0);
        run(FIPS_KEY, 100, 0, 1'b1);
        run(FIPS_KEY, 100, 3, 1'b0);
        ifc.ready = 1'b1;
        repeat (3) begin
            step();
            check("idle_rdy", {126'b0, ifc.valid, ifc.finish}, 128'd0);
            check("idle_key", ifc.round_key, FIPS_KEY);
        end
        ifc.ready = 1'b0;
        for (int i = 0; i < 100; i++)
            run({$urandom, $urandom, $urandom, $urandom}, $urandom_range(30, 100), 0, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
